// File: rtl/mem_bank_2rw_sched_if.sv
// rtl/mem_bank_2rw_sched_if.sv - request/response channels and two memory RW ports for the bank scheduler
interface mem_bank_2rw_sched_if #(
   parameter int REG_DEPTH = 4,
   parameter int REG_WIDTH = 64
);
   localparam int AW = $clog2(REG_DEPTH);

   logic                 req0_valid, req0_ready, req0_wr;
   logic [AW-1:0]        req0_addr;
   logic [REG_WIDTH-1:0] req0_wmask, req0_wdata;
   logic                 req1_valid, req1_ready, req1_wr;
   logic [AW-1:0]        req1_addr;
   logic [REG_WIDTH-1:0] req1_wmask, req1_wdata;

   logic                 rsp0_valid, rsp1_valid;
   logic [REG_WIDTH-1:0] rsp0_rdata, rsp1_rdata;

   logic                 RW0_wmode, RW1_wmode;
   logic [AW-1:0]        RW0_addr, RW1_addr;
   logic [REG_WIDTH-1:0] RW0_wmask, RW0_wdata, RW0_rdata;
   logic [REG_WIDTH-1:0] RW1_wmask, RW1_wdata, RW1_rdata;

   logic                 init_done;
   logic [7:0]           merge_cnt;

   modport slave (
      input  req0_valid, req0_wr, req0_addr, req0_wmask, req0_wdata,
      input  req1_valid, req1_wr, req1_addr, req1_wmask, req1_wdata,
      output req0_ready, req1_ready,
      output rsp0_valid, rsp0_rdata, rsp1_valid, rsp1_rdata,
      output RW0_wmode, RW0_addr, RW0_wmask, RW0_wdata,
      output RW1_wmode, RW1_addr, RW1_wmask, RW1_wdata,
      input  RW0_rdata, RW1_rdata,
      output init_done, merge_cnt
   );

   modport master (
      output req0_valid, req0_wr, req0_addr, req0_wmask, req0_wdata,
      output req1_valid, req1_wr, req1_addr, req1_wmask, req1_wdata,
      input  req0_ready, req1_ready,
      input  rsp0_valid, rsp0_rdata, rsp1_valid, rsp1_rdata,
      input  RW0_wmode, RW0_addr, RW0_wmask, RW0_wdata,
      input  RW1_wmode, RW1_addr, RW1_wmask, RW1_wdata,
      output RW0_rdata, RW1_rdata,
      input  init_done, merge_cnt
   );
endinterface

// File: rtl/mem_bank_2rw_sched.sv
// rtl/mem_bank_2rw_sched.sv - two-channel scheduler onto a 2RW memory bank with init clear and same-address write merge
module mem_bank_2rw_sched #(
   parameter int REG_DEPTH = 4,
   parameter int REG_WIDTH = 64
) (
   input logic                  clk,
   input logic                  rst,
   mem_bank_2rw_sched_if.slave  bus
);
   localparam int AW = $clog2(REG_DEPTH);
   localparam logic [AW-1:0] INIT_LAST = AW'(REG_DEPTH / 2 - 1);

   typedef enum logic {S_INIT, S_RUN} state_t;

   state_t               state, state_nxt;
   logic [AW-1:0]        init_cnt, init_cnt_nxt;
   logic                 acc0, acc1, rd0, rd1, merge;
   logic                 rsp0_valid_q, rsp1_valid_q;
   logic [REG_WIDTH-1:0] rsp0_rdata_q, rsp1_rdata_q;
   logic [7:0]           merge_cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_INIT;
         init_cnt     <= '0;
         rsp0_valid_q <= 1'b0;
         rsp1_valid_q <= 1'b0;
         rsp0_rdata_q <= '0;
         rsp1_rdata_q <= '0;
         merge_cnt_q  <= '0;
      end else begin
         state        <= state_nxt;
         init_cnt     <= init_cnt_nxt;
         rsp0_valid_q <= rd0;
         rsp1_valid_q <= rd1;
         if (rd0) rsp0_rdata_q <= bus.RW0_rdata;
         if (rd1) rsp1_rdata_q <= bus.RW1_rdata;
         if (merge && merge_cnt_q != 8'hFF) merge_cnt_q <= merge_cnt_q + 8'd1;
      end
   end

   always_comb begin
      state_nxt      = state;
      init_cnt_nxt   = init_cnt;
      acc0           = 1'b0;
      acc1           = 1'b0;
      rd0            = 1'b0;
      rd1            = 1'b0;
      merge          = 1'b0;
      bus.RW0_wmode  = 1'b0;
      bus.RW0_addr   = bus.req0_addr;
      bus.RW0_wmask  = bus.req0_wmask;
      bus.RW0_wdata  = bus.req0_wdata;
      bus.RW1_wmode  = 1'b0;
      bus.RW1_addr   = bus.req1_addr;
      bus.RW1_wmask  = bus.req1_wmask;
      bus.RW1_wdata  = bus.req1_wdata;
      if (state == S_INIT) begin
         // Each init cycle clears an even/odd word pair, one per port.
         bus.RW0_wmode = 1'b1;
         bus.RW0_addr  = init_cnt << 1;
         bus.RW0_wmask = '1;
         bus.RW0_wdata = '0;
         bus.RW1_wmode = 1'b1;
         bus.RW1_addr  = (init_cnt << 1) | AW'(1);
         bus.RW1_wmask = '1;
         bus.RW1_wdata = '0;
         if (init_cnt == INIT_LAST) state_nxt = S_RUN;
         else                       init_cnt_nxt = init_cnt + AW'(1);
      end else begin
         acc0  = bus.req0_valid;
         acc1  = bus.req1_valid;
         rd0   = acc0 && !bus.req0_wr;
         rd1   = acc1 && !bus.req1_wr;
         merge = acc0 && acc1 && bus.req0_wr && bus.req1_wr && (bus.req0_addr == bus.req1_addr);
         bus.RW0_wmode = acc0 && bus.req0_wr;
         bus.RW1_wmode = acc1 && bus.req1_wr && !merge;
         if (merge) begin
            // Channel 1 owns any bit both channels enable.
            bus.RW0_wmask = bus.req0_wmask | bus.req1_wmask;
            bus.RW0_wdata = (bus.req1_wdata & bus.req1_wmask) | (bus.req0_wdata & ~bus.req1_wmask);
         end
      end
   end

   assign bus.req0_ready = (state == S_RUN);
   assign bus.req1_ready = (state == S_RUN);
   assign bus.init_done  = (state == S_RUN);
   assign bus.rsp0_valid = rsp0_valid_q;
   assign bus.rsp1_valid = rsp1_valid_q;
   assign bus.rsp0_rdata = rsp0_rdata_q;
   assign bus.rsp1_rdata = rsp1_rdata_q;
   assign bus.merge_cnt  = merge_cnt_q;
endmodule
